// File: rtl/psram_cache.sv
// rtl/psram_cache.sv - direct-mapped write-through one-word-line cache in front of the PSRAM controller
// Upstream and downstream share the same pulse/ready handshake.
module psram_cache #(
    parameter int LINES = 256,
    parameter int IDX_W = $clog2(LINES)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [21:0] a,
    input  logic [31:0] d,
    input  logic        we,
    input  logic        rd,
    output logic [31:0] spo,
    output logic        ready,
    input  logic        flush,
    output logic [21:0] mem_a,
    output logic [31:0] mem_d,
    output logic        mem_we,
    output logic        mem_rd,
    input  logic [31:0] mem_spo,
    input  logic        mem_ready,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);
    localparam int TAG_W = 22 - IDX_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HIT,
        S_MEM_REQ,
        S_MEM_WAIT_LO,
        S_MEM_WAIT_HI,
        S_FILL
    } state_t;

    state_t             state_q, state_d;
    logic               ready_q, ready_d;
    logic [31:0]        spo_q, spo_d;
    logic               mem_rd_q, mem_rd_d;
    logic               mem_we_q, mem_we_d;
    logic [21:0]        mem_a_q, mem_a_d;
    logic [31:0]        mem_d_q, mem_d_d;
    logic [31:0]        hit_q, hit_d;
    logic [31:0]        miss_q, miss_d;
    logic [LINES-1:0]   valid_q, valid_d;
    logic [21:0]        a_q, a_d;
    logic [31:0]        wd_q, wd_d;
    logic               is_wr_q, is_wr_d;

    logic [TAG_W-1:0]   tag_mem  [LINES];
    logic [31:0]        data_mem [LINES];

    logic               arr_we;
    logic [IDX_W-1:0]   arr_idx;
    logic [TAG_W-1:0]   arr_tag;
    logic [31:0]        arr_data;

    logic [IDX_W-1:0]   req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic [IDX_W-1:0]   lat_idx;
    logic [TAG_W-1:0]   lat_tag;
    logic               hit;

    assign req_idx = a[IDX_W-1:0];
    assign req_tag = a[21:IDX_W];
    assign lat_idx = a_q[IDX_W-1:0];
    assign lat_tag = a_q[21:IDX_W];
    assign hit     = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

    assign ready    = ready_q & ~(rd | we);
    assign spo      = spo_q;
    assign mem_rd   = mem_rd_q;
    assign mem_we   = mem_we_q;
    assign mem_a    = mem_a_q;
    assign mem_d    = mem_d_q;
    assign hit_cnt  = hit_q;
    assign miss_cnt = miss_q;

    always_comb begin
        state_d  = state_q;
        ready_d  = ready_q;
        spo_d    = spo_q;
        mem_rd_d = 1'b0;
        mem_we_d = 1'b0;
        mem_a_d  = mem_a_q;
        mem_d_d  = mem_d_q;
        hit_d    = hit_q;
        miss_d   = miss_q;
        valid_d  = valid_q;
        a_d      = a_q;
        wd_d     = wd_q;
        is_wr_d  = is_wr_q;
        arr_we   = 1'b0;
        arr_idx  = lat_idx;
        arr_tag  = lat_tag;
        arr_data = mem_spo;

        case (state_q)
            S_IDLE: begin
                a_d  = a;
                wd_d = d;
                if (we) begin
                    // Write-through: allocate now, the PSRAM copy follows.
                    arr_we           = 1'b1;
                    arr_idx          = req_idx;
                    arr_tag          = req_tag;
                    arr_data         = d;
                    valid_d[req_idx] = 1'b1;
                    ready_d          = 1'b0;
                    is_wr_d          = 1'b1;
                    state_d          = S_MEM_REQ;
                end else if (rd) begin
                    ready_d = 1'b0;
                    if (hit) begin
                        spo_d   = data_mem[req_idx];
                        hit_d   = hit_q + 32'd1;
                        state_d = S_HIT;
                    end else begin
                        miss_d  = miss_q + 32'd1;
                        is_wr_d = 1'b0;
                        state_d = S_MEM_REQ;
                    end
                end else if (flush) begin
                    valid_d = '0;
                end
            end
            S_HIT, S_FILL: begin
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
            S_MEM_REQ: begin
                if (mem_ready) begin
                    mem_rd_d = ~is_wr_q;
                    mem_we_d = is_wr_q;
                    mem_a_d  = a_q;
                    mem_d_d  = wd_q;
                    state_d  = S_MEM_WAIT_LO;
                end
            end
            S_MEM_WAIT_LO: begin
                // ready dropping is the controller's acceptance of the pulse
                if (!mem_ready) state_d = S_MEM_WAIT_HI;
            end
            S_MEM_WAIT_HI: begin
                if (mem_ready) begin
                    if (is_wr_q) begin
                        ready_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        spo_d            = mem_spo;
                        arr_we           = 1'b1;
                        valid_d[lat_idx] = 1'b1;
                        state_d          = S_FILL;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            ready_q  <= 1'b1;
            spo_q    <= '0;
            mem_rd_q <= 1'b0;
            mem_we_q <= 1'b0;
            mem_a_q  <= '0;
            mem_d_q  <= '0;
            hit_q    <= '0;
            miss_q   <= '0;
            valid_q  <= '0;
            a_q      <= '0;
            wd_q     <= '0;
            is_wr_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            spo_q    <= spo_d;
            mem_rd_q <= mem_rd_d;
            mem_we_q <= mem_we_d;
            mem_a_q  <= mem_a_d;
            mem_d_q  <= mem_d_d;
            hit_q    <= hit_d;
            miss_q   <= miss_d;
            valid_q  <= valid_d;
            a_q      <= a_d;
            wd_q     <= wd_d;
            is_wr_q  <= is_wr_d;
        end
    end

    // Tag/data arrays carry no reset; valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (arr_we) begin
            tag_mem[arr_idx]  <= arr_tag;
            data_mem[arr_idx] <= arr_data;
        end
    end

endmodule

// File: tb/tb_psram_cache.sv
// tb/tb_psram_cache.sv - directed self-checking bench for psram_cache
// A behavioural controller model answers each pulse after mem_lat cycles.
module tb_psram_cache;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [21:0] a = '0;
    logic [31:0] d = '0;
    logic        we = 1'b0;
    logic        rd = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] spo;
    logic        ready;
    logic [21:0] mem_a;
    logic [31:0] mem_d;
    logic        mem_we;
    logic        mem_rd;
    logic [31:0] mem_spo = '0;
    logic        mem_ready = 1'b1;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    int          n_cmp = 0;
    int          n_mis = 0;
    int          n_mem_rd = 0;
    int          n_mem_we = 0;
    logic [21:0] last_a = '0;
    logic [31:0] last_d = '0;
    logic [31:0] mem_resp = '0;
    int          mem_lat = 20;
    bit          mem_hold = 1'b0;
    logic        was_rd;
    int          rd_base;

    psram_cache #(.LINES(256)) dut (
        .clk(clk), .rst(rst), .a(a), .d(d), .we(we), .rd(rd),
        .spo(spo), .ready(ready), .flush(flush),
        .mem_a(mem_a), .mem_d(mem_d), .mem_we(mem_we), .mem_rd(mem_rd),
        .mem_spo(mem_spo), .mem_ready(mem_ready),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_rd) begin n_mem_rd++; last_a = mem_a; end
        if (mem_we) begin n_mem_we++; last_a = mem_a; last_d = mem_d; end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (mem_rd === 1'b1 || mem_we === 1'b1) begin
                was_rd    = mem_rd;
                mem_ready = 1'b0;
                repeat (mem_lat) @(negedge clk);
                if (was_rd) mem_spo = mem_resp;
                mem_ready = 1'b1;
            end else begin
                mem_ready = !mem_hold;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_read(input logic [21:0] addr, input bit with_flush);
        @(negedge clk);
        a = addr; rd = 1'b1; flush = with_flush;
        #1 check_eq("rd_forces_ready_low", 32'(ready), 32'd0);
        @(negedge clk);
        rd = 1'b0; flush = 1'b0;
    endtask

    task automatic do_write(input logic [21:0] addr, input logic [31:0] data);
        @(negedge clk);
        a = addr; d = data; we = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic wait_ready(input string tag, input int budget);
        int n = 0;
        while (ready !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 32'(ready), 32'd1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_eq("rst_ready", 32'(ready), 32'd1);
        check_eq("rst_spo", spo, 32'd0);
        check_eq("rst_hit", hit_cnt, 32'd0);
        check_eq("rst_miss", miss_cnt, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // first read of 0x10 misses and fetches
        mem_resp = 32'hDEADBEEF;
        do_read(22'h000010, 1'b0);
        wait_ready("miss1_ready", 100);
        check_eq("miss1_spo", spo, 32'hDEADBEEF);
        check_eq("miss1_cnt", miss_cnt, 32'd1);
        check_eq("miss1_memrd", 32'(n_mem_rd), 32'd1);
        check_eq("miss1_mem_a", 32'(last_a), 32'h000010);

        // second read hits with one-cycle latency
        do_read(22'h000010, 1'b0);
        @(negedge clk);
        check_eq("hit1_ready", 32'(ready), 32'd1);
        check_eq("hit1_spo", spo, 32'hDEADBEEF);
        check_eq("hit1_cnt", hit_cnt, 32'd1);
        check_eq("hit1_memrd", 32'(n_mem_rd), 32'd1);

        // write to same index, different tag
        do_write(22'h000110, 32'h12345678);
        wait_ready("wr_ready", 100);
        check_eq("wr_memwe", 32'(n_mem_we), 32'd1);
        check_eq("wr_mem_a", 32'(last_a), 32'h000110);
        check_eq("wr_mem_d", last_d, 32'h12345678);

        do_read(22'h000110, 1'b0);
        @(negedge clk);
        check_eq("hit2_spo", spo, 32'h12345678);
        check_eq("hit2_cnt", hit_cnt, 32'd2);
        check_eq("hit2_memrd", 32'(n_mem_rd), 32'd1);

        mem_resp = 32'hDEADBEEF;
        do_read(22'h000010, 1'b0);
        wait_ready("refetch_ready", 100);
        check_eq("refetch_miss", miss_cnt, 32'd2);
        check_eq("refetch_memrd", 32'(n_mem_rd), 32'd2);
        check_eq("refetch_spo", spo, 32'hDEADBEEF);

        // flush alone invalidates, ready stays high
        @(negedge clk);
        flush = 1'b1;
        #1 check_eq("flush_ready", 32'(ready), 32'd1);
        @(negedge clk);
        flush = 1'b0;
        mem_resp = 32'h0BADF00D;
        do_read(22'h000010, 1'b0);
        wait_ready("postflush_ready", 100);
        check_eq("postflush_miss", miss_cnt, 32'd3);
        check_eq("postflush_memrd", 32'(n_mem_rd), 32'd3);
        check_eq("postflush_spo", spo, 32'h0BADF00D);

        // flush together with rd is ignored
        do_read(22'h000010, 1'b1);
        @(negedge clk);
        check_eq("rdflush_spo", spo, 32'h0BADF00D);
        check_eq("rdflush_hit", hit_cnt, 32'd3);
        do_read(22'h000010, 1'b0);
        @(negedge clk);
        check_eq("rdflush_still_hit", hit_cnt, 32'd4);
        check_eq("rdflush_memrd", 32'(n_mem_rd), 32'd3);

        // reset while waiting for read data
        mem_resp = 32'h55555555;
        do_read(22'h000200, 1'b0);
        begin
            int n = 0;
            while (mem_ready !== 1'b0 && n < 50) begin @(negedge clk); n++; end
        end
        check_eq("mid_accepted", 32'(mem_ready), 32'd0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_eq("mid_rst_mem_rd", 32'(mem_rd), 32'd0);
        check_eq("mid_rst_ready", 32'(ready), 32'd1);
        check_eq("mid_rst_spo", spo, 32'd0);
        check_eq("mid_rst_hit", hit_cnt, 32'd0);
        check_eq("mid_rst_miss", miss_cnt, 32'd0);
        check_eq("mid_rst_mem_a", 32'(mem_a), 32'd0);
        check_eq("mid_rst_mem_d", mem_d, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        begin
            int n = 0;
            while (mem_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        end
        check_eq("mid_ctrl_idle", 32'(mem_ready), 32'd1);
        rd_base  = n_mem_rd;
        mem_resp = 32'h11110010;
        do_read(22'h000010, 1'b0);
        wait_ready("postrst_ready", 100);
        check_eq("postrst_miss", miss_cnt, 32'd1);
        check_eq("postrst_hit", hit_cnt, 32'd0);
        check_eq("postrst_memrd", 32'(n_mem_rd - rd_base), 32'd1);
        check_eq("postrst_spo", spo, 32'h11110010);

        // controller busy: request waits, pulses while busy are ignored
        mem_hold = 1'b1;
        repeat (2) @(negedge clk);
        rd_base  = n_mem_rd;
        do_read(22'h000300, 1'b0);
        repeat (50) @(negedge clk);
        check_eq("busy_no_memrd", 32'(n_mem_rd - rd_base), 32'd0);
        do_read(22'h000010, 1'b0);
        @(negedge clk);
        check_eq("busy_hit_unch", hit_cnt, 32'd0);
        check_eq("busy_miss_unch", miss_cnt, 32'd2);
        mem_resp = 32'h30303030;
        mem_hold = 1'b0;
        wait_ready("busy_ready", 100);
        check_eq("busy_memrd", 32'(n_mem_rd - rd_base), 32'd1);
        check_eq("busy_mem_a", 32'(last_a), 32'h000300);
        check_eq("busy_spo", spo, 32'h30303030);
        check_eq("busy_hit_end", hit_cnt, 32'd0);
        check_eq("busy_miss_end", miss_cnt, 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
